// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the MAC accumulate stage.
//   state_e   : accumulator FSM states (IDLE, ADD, OUT)
//   CHUNK_W   : width of the serial adder slice (one byte)
//   NCH       : chunk count for the default 40-bit accumulator
//   sign_ext  : sign-extend a product of width pw into a 64-bit container
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam int CHUNK_W    = 8;
    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int NCH        = ACC_W_DEF / CHUNK_W;

    // Width-agnostic so that any PROD_W/ACC_W pair up to 64 bits can use it;
    // the caller truncates the result to ACC_W.
    function automatic logic [63:0] sign_ext(input logic [63:0] p, input int unsigned pw);
        logic [63:0] hi_mask;
        hi_mask = {64{1'b1}} << pw;
        return p[pw-1] ? (p | hi_mask) : (p & ~hi_mask);
    endfunction

endpackage

// File: rtl/byte_add_slice.sv
// byte_add_slice: 8-bit combinational Kogge-Stone adder with carry-in.
// Ports:
//   a_i, b_i    : byte operands
//   cin_i       : carry into bit 0
//   sum_o       : a + b + cin (low 8 bits)
//   cout_o      : carry out of bit 7
//   msb_cin_o   : carry into bit 7 (XOR with cout gives signed overflow)
module byte_add_slice
    import mac_pkg::*;
(
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               cin_i,
    output logic [CHUNK_W-1:0] sum_o,
    output logic               cout_o,
    output logic               msb_cin_o
);

    logic [CHUNK_W-1:0]      g, p;
    logic [3:0][CHUNK_W-1:0] gg;   // group generate per prefix level
    logic [2:0][CHUNK_W-1:0] pp;   // group propagate per prefix level
    logic [CHUNK_W:0]        c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Folding cin into bit 0's generate makes every prefix group anchored at
    // bit 0 fully resolved, so gg[3][i] is directly the carry into bit i+1.
    assign gg[0] = {g[CHUNK_W-1:1], g[0] | (p[0] & cin_i)};
    assign pp[0] = p;

    for (genvar l = 0; l < 3; l++) begin : g_lvl
        for (genvar i = 0; i < CHUNK_W; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_op
                assign gg[l+1][i] = gg[l][i] | (pp[l][i] & gg[l][i-(1<<l)]);
                if (l < 2) begin : g_p
                    assign pp[l+1][i] = pp[l][i] & pp[l][i-(1<<l)];
                end
            end else begin : g_pass
                assign gg[l+1][i] = gg[l][i];
                if (l < 2) begin : g_p
                    assign pp[l+1][i] = pp[l][i];
                end
            end
        end
    end

    // Propagate bits below each level's span are never consumed.
    logic unused_pp;
    assign unused_pp = ^{pp[0][0], pp[1][1:0], pp[2][3:0]};

    assign c[0]          = cin_i;
    assign c[CHUNK_W:1]  = gg[3];
    assign sum_o         = p ^ c[CHUNK_W-1:0];
    assign cout_o        = c[CHUNK_W];
    assign msb_cin_o     = c[CHUNK_W-1];

endmodule

// File: rtl/mac_serial_accumulator.sv
// mac_serial_accumulator: byte-serial accumulate stage behind the 16x16 multiplier.
// Each accepted signed product is added into the accumulator one byte per cycle
// through a single byte_add_slice; a product marked last raises out_valid.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   clr                   : clear acc/ovf (IDLE only)
//   in_valid/in_ready     : product handshake; in_prod, in_last payload
//   out_valid/out_ready   : result handshake; out_acc, out_ovf payload
//   busy                  : high in ADD or OUT
// Build option: SATURATE_EN clamps the accumulator on signed overflow
// instead of wrapping. ACC_W must be a multiple of 8, >= PROD_W, <= 64.
module mac_serial_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic              busy
);

    localparam int NCH_L = ACC_W / CHUNK_W;
    localparam int CW    = (NCH_L > 1) ? $clog2(NCH_L) : 1;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    op_q, op_d;
    logic                carry_q, carry_d;
    logic [CW-1:0]       chunk_q, chunk_d;
    logic                ovf_q, ovf_d;
    logic                last_q, last_d;

    logic [CHUNK_W-1:0]  a_byte, b_byte, s_byte;
    logic                s_cout, s_msb_cin;

    // Chunk mux: the slice only ever sees the byte selected by chunk_q.
    assign a_byte = acc_q[int'(chunk_q)*CHUNK_W +: CHUNK_W];
    assign b_byte = op_q[int'(chunk_q)*CHUNK_W +: CHUNK_W];

    byte_add_slice u_add (
        .a_i       (a_byte),
        .b_i       (b_byte),
        .cin_i     (carry_q),
        .sum_o     (s_byte),
        .cout_o    (s_cout),
        .msb_cin_o (s_msb_cin)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        carry_d = carry_q;
        chunk_d = chunk_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                // Clear is applied before a same-cycle accept, so that product
                // lands on a zeroed accumulator.
                if (clr) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                if (in_valid) begin
                    op_d    = ACC_W'(sign_ext(64'(in_prod), PROD_W));
                    last_d  = in_last;
                    chunk_d = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d[int'(chunk_q)*CHUNK_W +: CHUNK_W] = s_byte;
                carry_d = s_cout;
                chunk_d = chunk_q + CW'(1);
                if (chunk_q == CW'(NCH_L-1)) begin
                    ovf_d = ovf_q | (s_msb_cin ^ s_cout);
`ifdef SATURATE_EN
                    // Overflow is only possible when op and acc share a sign,
                    // so op's sign picks the rail.
                    if (s_msb_cin ^ s_cout) begin
                        acc_d = op_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}};
                    end
`endif
                    state_d = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            chunk_q <= '0;
            ovf_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            chunk_q <= chunk_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mac_serial_accumulator.sv
// Bench for mac_serial_accumulator: a 40-bit and a 32-bit instance share the
// stimulus bus; sel chooses which one sees handshakes. Expected results come
// from a signed-integer reference of the accumulate rules.
module tb_mac_serial_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, in_valid, in_last, out_ready, sel;
    logic [31:0] in_prod;

    logic        rdy40, ov40, ovf40, busy40;
    logic [39:0] acc40;
    logic        rdy32, ov32, ovf32, busy32;
    logic [31:0] acc32;

    mac_serial_accumulator #(.PROD_W(32), .ACC_W(40)) dut40 (
        .clk(clk), .rst(rst), .clr(clr & ~sel), .in_valid(in_valid & ~sel),
        .in_ready(rdy40), .in_prod(in_prod), .in_last(in_last),
        .out_valid(ov40), .out_ready(out_ready & ~sel), .out_acc(acc40),
        .out_ovf(ovf40), .busy(busy40)
    );

    mac_serial_accumulator #(.PROD_W(32), .ACC_W(32)) dut32 (
        .clk(clk), .rst(rst), .clr(clr & sel), .in_valid(in_valid & sel),
        .in_ready(rdy32), .in_prod(in_prod), .in_last(in_last),
        .out_valid(ov32), .out_ready(out_ready & sel), .out_acc(acc32),
        .out_ovf(ovf32), .busy(busy32)
    );

    logic        m_rdy, m_ov, m_ovf, m_busy;
    logic [63:0] m_acc_o;
    assign m_rdy   = sel ? rdy32  : rdy40;
    assign m_ov    = sel ? ov32   : ov40;
    assign m_ovf   = sel ? ovf32  : ovf40;
    assign m_busy  = sel ? busy32 : busy40;
    assign m_acc_o = sel ? 64'(acc32) : 64'(acc40);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc, seen_cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: signed integer sum with range check.
    longint ref_acc;
    bit     ref_ovf;

    function automatic int wid();
        return sel ? 32 : 40;
    endfunction

    function automatic logic [63:0] ref_bits();
        logic [63:0] mask;
        mask = (64'd1 << wid()) - 64'd1;
        return 64'(ref_acc) & mask;
    endfunction

    task automatic ref_add(input logic [31:0] p);
        longint sp, s, hi, lo, span;
        sp   = longint'($signed(p));
        span = longint'(1) <<< wid();
        hi   = (span >>> 1) - 1;
        lo   = -(span >>> 1);
        s    = ref_acc + sp;
        if (s > hi || s < lo) begin
            ref_ovf = 1'b1;
`ifdef SATURATE_EN
            s = (sp >= 0) ? hi : lo;
`else
            s = (s > hi) ? s - span : s + span;
`endif
        end
        ref_acc = s;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge.
    task automatic send(input logic [31:0] p, input logic last, input logic c);
        for (int i = 0; i < 50 && !m_rdy; i++) @(negedge clk);
        if (!m_rdy) begin
            chk("rdy_wait", 64'(m_rdy), 64'd1);
            return;
        end
        in_prod  = p;
        in_last  = last;
        clr      = c;
        in_valid = 1'b1;
        acc_cyc  = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
        if (c) begin
            ref_acc = 0;
            ref_ovf = 1'b0;
        end
        ref_add(p);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 60 && !m_ov; i++) @(negedge clk);
        seen_cyc = cyc;
        if (!m_ov) chk("out_wait", 64'(m_ov), 64'd1);
    endtask

    task automatic get_result(input string tag, input int stall);
        wait_out();
        for (int i = 0; i < stall; i++) @(negedge clk);
        chk({tag, "_acc"}, m_acc_o, ref_bits());
        chk({tag, "_ovf"}, 64'(m_ovf), 64'(ref_ovf));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        ref_acc = 0;
        ref_ovf = 1'b0;
    endtask

    initial begin
        int first_cyc, n, seen;
        logic [31:0] p;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; sel = 1'b0; in_prod = '0;
        ref_acc = 0; ref_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_rdy",   64'(rdy40), 64'd1);
        chk("rst_ov",    64'(ov40),  64'd0);
        chk("rst_busy",  64'(busy40), 64'd0);
        chk("rst_acc",   64'(acc40), 64'd0);
        chk("rst_ovf",   64'(ovf40), 64'd0);
        chk("rst_acc32", 64'(acc32), 64'd0);

        // 3 + 5, latency: two products at NCH+1 cycles each
        send(32'd3, 1'b0, 1'b0);
        first_cyc = acc_cyc;
        chk("add_busy", 64'(m_busy), 64'd1);
        send(32'd5, 1'b1, 1'b0);
        wait_out();
        chk("latency", 64'(seen_cyc - first_cyc), 64'(2 * (wid() / 8 + 1)));
        get_result("t2", 0);

        // carry between chunks 0 and 1
        send(32'h0000_00FF, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b1, 1'b0);
        get_result("t3", 0);

        // -1 + 2
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'h0000_0002, 1'b1, 1'b0);
        get_result("t4", 0);

        // 32-bit accumulator overflow
        sel = 1'b1;
        @(negedge clk);
        send(32'h7FFF_FFFF, 1'b0, 1'b0);
        send(32'h0000_0001, 1'b1, 1'b0);
        get_result("t5", 0);
        sel = 1'b0;
        @(negedge clk);

        // output stall: result held, input blocked
        send(32'd11, 1'b0, 1'b0);
        send(32'hFFFF_FFF0, 1'b1, 1'b0);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            chk("stall_acc", m_acc_o, ref_bits());
            chk("stall_rdy", 64'(m_rdy), 64'd0);
            @(negedge clk);
        end
        get_result("t6", 0);

        // clr with same-cycle accept on a non-empty accumulator
        send(32'd100, 1'b0, 1'b0);
        send(32'd7, 1'b1, 1'b1);
        get_result("clr", 0);

        // reset mid-ADD: no result follows
        send(32'd9, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_acc = 0;
        ref_ovf = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_ov) seen++;
            @(negedge clk);
        end
        chk("rst_mid_ov", 64'(seen), 64'd0);
        chk("rst_mid_acc", m_acc_o, ref_bits());

        // randomized dot products on both widths
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            for (int d = 0; d < 8; d++) begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    case ($urandom_range(0, 3))
                        0: p = 32'h7FFF_FFFF;
                        1: p = 32'h8000_0000;
                        default: p = $urandom;
                    endcase
                    send(p, k == n - 1, (k != 0) && ($urandom_range(0, 3) == 0));
                end
                get_result("rnd", $urandom_range(0, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
